// File: rtl/rvvi_retire_queue.sv
// Multi-hart, multi-lane retirement capture queue serialised onto one valid/ready trace stream.
// Optional per-hart order-gap checker enabled by defining RVVI_RETIRE_ORDER_CHECK_EN.
module rvvi_retire_queue #(
  parameter int NHART  = 2,
  parameter int RETIRE = 2,
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NHART*RETIRE-1:0]               valid,
  input  logic [NHART*RETIRE*64-1:0]            order,
  input  logic [NHART*RETIRE*ILEN-1:0]          insn,
  input  logic [NHART*RETIRE*XLEN-1:0]          pc_rdata,
  input  logic [NHART*RETIRE-1:0]               trap,
  input  logic [NHART*RETIRE*2-1:0]             mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [((NHART > 1) ? $clog2(NHART) : 1)-1:0] out_hart,
  output logic [63:0]                           out_order,
  output logic [ILEN-1:0]                       out_insn,
  output logic [XLEN-1:0]                       out_pc,
  output logic                                  out_trap,
  output logic [1:0]                            out_mode,
  output logic [NHART-1:0]                      overflow,
  output logic [NHART-1:0]                      gap_err
);

  // Handshake: an entry transfers on a rising edge where out_valid && out_ready;
  // once out_valid is high the presented entry and out_hart hold until that transfer.

  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 64 + ILEN + XLEN + 3;

  logic [EW-1:0]     mem [NHART][DEPTH];
  logic [AW-1:0]     wr_ptr [NHART];
  logic [AW-1:0]     rd_ptr [NHART];
  logic [CW-1:0]     count [NHART];
  logic [CW-1:0]     n_push [NHART];
  logic [AW-1:0]     slot [NHART][RETIRE];
  logic [EW-1:0]     lane_entry [NHART][RETIRE];
  logic [NHART-1:0]  accept;
  logic [NHART-1:0]  nonempty;
  logic [NHART-1:0]  pop_vec;

  logic [HW-1:0]     last_grant;
  logic [HW-1:0]     lock_hart;
  logic [HW-1:0]     rr_pick;
  logic [HW-1:0]     grant;
  logic              lock;
  logic              rr_found;
  logic              pop;
  logic [EW-1:0]     head;

  function automatic logic [AW-1:0] wrap(input int unsigned x);
    return AW'(x % DEPTH);
  endfunction

  // Compact valid lanes in ascending r onto consecutive slots after wr_ptr.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int h = 0; h < NHART; h++) begin
      cnt = 0;
      for (int r = 0; r < RETIRE; r++) begin
        lane_entry[h][r] = {order[(h*RETIRE+r)*64 +: 64],
                            insn[(h*RETIRE+r)*ILEN +: ILEN],
                            pc_rdata[(h*RETIRE+r)*XLEN +: XLEN],
                            trap[h*RETIRE+r],
                            mode[(h*RETIRE+r)*2 +: 2]};
        slot[h][r] = wrap(int'(wr_ptr[h]) + cnt);
        if (valid[h*RETIRE+r]) cnt = cnt + 1;
      end
      n_push[h]   = CW'(cnt);
      accept[h]   = (cnt != 0) && ((int'(count[h]) + cnt) <= DEPTH);
      nonempty[h] = (count[h] != '0);
    end
  end

  // Round-robin pick starting after last_grant; a stalled presentation stays locked.
  always_comb begin
    int idx;
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NHART; i++) begin
      idx = (int'(last_grant) + i) % NHART;
      if (!rr_found && nonempty[idx]) begin
        rr_pick  = HW'(idx);
        rr_found = 1'b1;
      end
    end
  end

  assign grant     = lock ? lock_hart : rr_pick;
  assign out_valid = |nonempty;
  assign pop       = out_valid && out_ready;
  assign head      = mem[grant][rd_ptr[grant]];
  assign out_hart  = out_valid ? grant : '0;
  assign {out_order, out_insn, out_pc, out_trap, out_mode} = out_valid ? head : '0;

  always_comb begin
    for (int h = 0; h < NHART; h++) pop_vec[h] = pop && (grant == HW'(h));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NHART; h++) begin
        count[h]  <= '0;
        wr_ptr[h] <= '0;
        rd_ptr[h] <= '0;
      end
      last_grant <= HW'(NHART - 1);
      lock       <= 1'b0;
      lock_hart  <= '0;
      overflow   <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        count[h] <= count[h] + (accept[h] ? n_push[h] : CW'(0)) - CW'(pop_vec[h]);
        if (accept[h]) wr_ptr[h] <= wrap(int'(wr_ptr[h]) + int'(n_push[h]));
        if (pop_vec[h]) rd_ptr[h] <= wrap(int'(rd_ptr[h]) + 1);
        if ((n_push[h] != '0) && !accept[h]) overflow[h] <= 1'b1;
      end
      lock      <= out_valid && !out_ready;
      lock_hart <= grant;
      if (pop) last_grant <= grant;
    end
  end

  always_ff @(posedge clk) begin
    for (int h = 0; h < NHART; h++) begin
      for (int r = 0; r < RETIRE; r++) begin
        if (accept[h] && valid[h*RETIRE+r]) mem[h][slot[h][r]] <= lane_entry[h][r];
      end
    end
  end

`ifdef RVVI_RETIRE_ORDER_CHECK_EN
  logic [63:0]      exp_ord [NHART];
  logic [63:0]      exp_nxt [NHART];
  logic [NHART-1:0] armed;
  logic [NHART-1:0] armed_nxt;
  logic [NHART-1:0] gap_q;
  logic [NHART-1:0] gap_nxt;

  // Every valid lane is checked, dropped or not; later lanes see the updated expectation.
  always_comb begin
    logic [63:0] e;
    logic        a;
    logic        g;
    e = '0;
    a = 1'b0;
    g = 1'b0;
    for (int h = 0; h < NHART; h++) begin
      e = exp_ord[h];
      a = armed[h];
      g = gap_q[h];
      for (int r = 0; r < RETIRE; r++) begin
        if (valid[h*RETIRE+r]) begin
          if (a && (order[(h*RETIRE+r)*64 +: 64] != e)) g = 1'b1;
          a = 1'b1;
          e = order[(h*RETIRE+r)*64 +: 64] + 64'd1;
        end
      end
      exp_nxt[h]   = e;
      armed_nxt[h] = a;
      gap_nxt[h]   = g;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NHART; h++) exp_ord[h] <= '0;
      armed <= '0;
      gap_q <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) exp_ord[h] <= exp_nxt[h];
      armed <= armed_nxt;
      gap_q <= gap_nxt;
    end
  end

  assign gap_err = gap_q;
`else
  assign gap_err = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_queue.sv
// Bench for rvvi_retire_queue (NHART=2, RETIRE=2, DEPTH=8): table vectors, corner sequences,
// per-hart expected queues filled by the driver and drained by an output monitor.
module tb_rvvi_retire_queue;
  localparam int DEPTH = 8;
  localparam int EW    = 64 + 32 + 32 + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   valid = '0;
  logic [255:0] order = '0;
  logic [127:0] insn = '0;
  logic [127:0] pc_rdata = '0;
  logic [3:0]   trap = '0;
  logic [7:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:0]   out_hart;
  logic [63:0]  out_order;
  logic [31:0]  out_insn;
  logic [31:0]  out_pc;
  logic         out_trap;
  logic [1:0]   out_mode;
  logic [1:0]   overflow;
  logic [1:0]   gap_err;

  rvvi_retire_queue #(.NHART(2), .RETIRE(2), .ILEN(32), .XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid(valid), .order(order), .insn(insn),
    .pc_rdata(pc_rdata), .trap(trap), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_hart(out_hart), .out_order(out_order),
    .out_insn(out_insn), .out_pc(out_pc), .out_trap(out_trap), .out_mode(out_mode),
    .overflow(overflow), .gap_err(gap_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [1:0]    exp_ovf = '0;
  int            got_hart[$];
  logic [63:0]   got_order[$];
  int            got_cyc[$];

  typedef struct packed {
    logic [3:0]   v;
    logic [255:0] o;
    logic [1:0]   gap;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [EW-1:0] mk(input logic [63:0] o);
    return {o, o[31:0] ^ 32'h1357_9bdf, {o[29:0], 2'b00}, o[0], o[2:1]};
  endfunction

  function automatic logic [255:0] ov(input logic [63:0] o0, o1, o2, o3);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [1:0] gx(input logic [1:0] g);
`ifdef RVVI_RETIRE_ORDER_CHECK_EN
    return g;
`else
    return 2'b00 & g;
`endif
  endfunction

  function automatic int qsize(input int h);
    return (h == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qpush(input int h, input logic [EW-1:0] e);
    if (h == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver: one cycle of lane stimulus; the scoreboard decides admission from its own occupancy
  task automatic drive(input logic [3:0] v, input logic [255:0] ol, input logic rdy);
    int n;
    for (int h = 0; h < 2; h++) begin
      n = 0;
      for (int r = 0; r < 2; r++) if (v[h*2+r]) n++;
      if (n > 0) begin
        if (qsize(h) + n <= DEPTH) begin
          for (int r = 0; r < 2; r++) if (v[h*2+r]) qpush(h, mk(ol[(h*2+r)*64 +: 64]));
        end else begin
          exp_ovf[h] = 1'b1;
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      insn[l*32 +: 32]     = ol[l*64 +: 32] ^ 32'h1357_9bdf;
      pc_rdata[l*32 +: 32] = {ol[l*64 +: 30], 2'b00};
      trap[l]              = ol[l*64];
      mode[l*2 +: 2]       = ol[l*64+1 +: 2];
    end
    order     = ol;
    valid     = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
    valid = '0;
  endtask

  task automatic idle(input int k, input logic rdy);
    repeat (k) drive(4'b0000, '0, rdy);
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    exp_ovf = '0;
  endtask

  task automatic clear_log();
    got_hart.delete();
    got_order.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  // monitor: compare every accepted entry against the head of its hart's expected queue
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_hart.push_back(int'(out_hart));
      got_order.push_back(out_order);
      got_cyc.push_back(cyc);
      if (qsize(int'(out_hart)) == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected hart=%0d act_order=%0d exp=no_output", out_hart, out_order);
      end else if (out_hart == 1'b0) begin
        chk("sb_hart0", {out_order, out_insn, out_pc, out_trap, out_mode}, exp_q0.pop_front());
      end else begin
        chk("sb_hart1", {out_order, out_insn, out_pc, out_trap, out_mode}, exp_q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_o [4];
    int exp_h [4];

    tbl[0] = '{v: 4'b0011, o: ov(1, 2, 0, 0),       gap: 2'b00};
    tbl[1] = '{v: 4'b0101, o: ov(3, 0, 100, 0),     gap: 2'b00};
    tbl[2] = '{v: 4'b1111, o: ov(4, 5, 101, 102),   gap: 2'b00};
    tbl[3] = '{v: 4'b0000, o: ov(0, 0, 0, 0),       gap: 2'b00};
    tbl[4] = '{v: 4'b1100, o: ov(0, 0, 103, 105),   gap: 2'b10};
    tbl[5] = '{v: 4'b0010, o: ov(0, 6, 0, 0),       gap: 2'b10};
    tbl[6] = '{v: 4'b1010, o: ov(0, 9, 0, 106),     gap: 2'b11};
    tbl[7] = '{v: 4'b0000, o: ov(0, 0, 0, 0),       gap: 2'b11};

    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hart", out_hart, 0);
    chk("rst_out_order", out_order, 0);
    chk("rst_out_insn", out_insn, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_trap_mode", {out_trap, out_mode}, 0);
    chk("rst_flags", {overflow, gap_err}, 0);
    reset = 1'b0;

    // two lanes of hart0 in one cycle drain on consecutive cycles
    clear_log();
    drive(4'b0011, ov(1, 2, 0, 0), 1'b1);
    idle(4, 1'b1);
    chk("t2_count", got_order.size(), 2);
    if (got_order.size() >= 2) begin
      chk("t2_first", got_order[0], 1);
      chk("t2_second", got_order[1], 2);
      chk("t2_harts", {got_hart[0][0], got_hart[1][0]}, 0);
      chk("t2_consecutive", got_cyc[1] - got_cyc[0], 1);
    end
    chk("t2_flags", {overflow, gap_err}, 0);

    // round-robin alternation from reset priority
    do_reset();
    drive(4'b0101, ov(10, 0, 20, 0), 1'b1);
    drive(4'b0101, ov(11, 0, 21, 0), 1'b1);
    idle(5, 1'b1);
    exp_o = '{10, 20, 11, 21};
    exp_h = '{0, 1, 0, 1};
    chk("t3_count", got_order.size(), 4);
    for (int i = 0; i < 4 && i < got_order.size(); i++) begin
      chk("t3_order", got_order[i], exp_o[i]);
      chk("t3_hart", got_hart[i], exp_h[i]);
    end

    // table vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].o, 1'b1);
      chk("tbl_overflow", overflow, exp_ovf);
      chk("tbl_gap", gap_err, gx(tbl[i].gap));
    end
    idle(20, 1'b1);
    chk("tbl_drained", qsize(0) + qsize(1), 0);
    chk("tbl_idle_valid", out_valid, 0);

    // fill to DEPTH with consumer stalled, then overflow while head is held
    do_reset();
    for (int i = 0; i < 4; i++) drive(4'b0011, ov(2*i+1, 2*i+2, 0, 0), 1'b0);
    chk("full_valid", out_valid, 1);
    chk("full_head", out_order, 1);
    drive(4'b0001, ov(9, 0, 0, 0), 1'b0);
    chk("full_overflow", overflow, 2'b01);
    chk("full_overflow_model", overflow, exp_ovf);
    chk("full_head_held", {out_hart, out_order}, {1'b0, 64'd1});
    // pop does not make room for a same-cycle push; next cycle's push fits
    drive(4'b0001, ov(10, 0, 0, 0), 1'b1);
    drive(4'b0001, ov(11, 0, 0, 0), 1'b0);
    chk("full_next_head", out_order, 2);
    chk("full_hart1_clean", overflow[1], 0);
    chk("full_gap", gap_err, 0);
    idle(12, 1'b1);
    chk("full_drained", qsize(0), 0);

    // single upper lane, then order gap
    do_reset();
    drive(4'b0010, ov(0, 5, 0, 0), 1'b1);
    chk("gap_none", gap_err, 0);
    drive(4'b0001, ov(7, 0, 0, 0), 1'b1);
    chk("gap_set", gap_err, gx(2'b01));
    drive(4'b0001, ov(8, 0, 0, 0), 1'b1);
    chk("gap_sticky", gap_err, gx(2'b01));
    idle(4, 1'b1);
    chk("gap_count", got_order.size(), 3);
    if (got_order.size() >= 1) chk("gap_first", got_order[0], 5);

    // grant lock: stalled hart1 presentation survives a hart0 arrival
    do_reset();
    drive(4'b0100, ov(0, 0, 30, 0), 1'b0);
    drive(4'b0001, ov(40, 0, 0, 0), 1'b0);
    chk("lock_hold", {out_hart, out_order}, {1'b1, 64'd30});
    idle(1, 1'b0);
    chk("lock_hold2", {out_hart, out_order}, {1'b1, 64'd30});
    idle(5, 1'b1);
    chk("lock_count", got_order.size(), 2);
    if (got_order.size() >= 2) chk("lock_seq", {got_order[0], got_order[1]}, {64'd30, 64'd40});

    // asynchronous reset while a stalled entry is presented
    do_reset();
    drive(4'b0100, ov(0, 0, 50, 0), 1'b0);
    drive(4'b0100, ov(0, 0, 60, 0), 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0011, ov(2*i+1, 2*i+2, 0, 0), 1'b0);
    drive(4'b0001, ov(9, 0, 0, 0), 1'b0);
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_flags", {overflow, gap_err}, {2'b01, gx(2'b10)});
    #3;
    reset = 1'b1;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_flags", {overflow, gap_err}, 0);
    chk("mid_order", out_order, 0);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    drive(4'b0100, ov(0, 0, 70, 0), 1'b1);
    idle(3, 1'b1);
    chk("mid_count", got_order.size(), 1);
    if (got_order.size() >= 1) chk("mid_first", got_order[0], 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvvi_retire_queue.md
# rvvi_retire_queue

Parametrised multi-hart, multi-retire successor to the RVVI trace interface. It captures up to RETIRE retirements per cycle from each of NHART harts into per-hart FIFOs. It then serialises them onto one valid/ready stream for a single-ported trace consumer (scoreboard, tracer or DPI bridge). The optional checker flags order-count gaps per hart.

## Interface
Parameters:
- NHART, 2, number of harts (channels), ≥1
- RETIRE, 2, retirement lanes per hart per cycle, ≥1
- ILEN, 32, instruction width
- XLEN, 32, PC width
- DEPTH, 8, entries per hart FIFO, power of two, ≥RETIRE

Ports (lane index l = h*RETIRE + r):
- clk  in  1  interface clock
- reset  in  1  asynchronous, active-high reset
- valid  in  NHART*RETIRE  retirement present on lane
- order  in  NHART*RETIRE*64  order count per lane
- insn  in  NHART*RETIRE*ILEN  instruction bits per lane
- pc_rdata  in  NHART*RETIRE*XLEN  PC per lane
- trap  in  NHART*RETIRE  trapped flag per lane
- mode  in  NHART*RETIRE*2  privilege mode per lane
- out_valid  out  1  entry presented
- out_ready  in  1  consumer accepts
- out_hart  out  $clog2(NHART) or 1  source hart
- out_order / out_insn / out_pc / out_trap / out_mode  out  64/ILEN/XLEN/1/2  entry fields
- overflow  out  NHART  sticky: a cycle's retirements were dropped
- gap_err  out  NHART  sticky: order discontinuity seen

## Operation
- Per-hart FIFO of DEPTH entries {order, insn, pc, trap, mode}; count width $clog2(DEPTH)+1.
- Write: for hart h, n = popcount(valid lanes of h). The valid lanes are compacted in ascending r and written in one cycle.
- Admission is all-or-nothing: accept iff count_h + n ≤ DEPTH, using count_h at the start of the cycle. A same-cycle pop does not create room. Otherwise drop all n, set overflow[h], and leave the FIFO unchanged.
- Read: round-robin arbiter over non-empty harts. Priority starts at hart (last_grant+1) mod NHART. After reset, last_grant = NHART-1, so hart 0 has priority first.
- Grant lock: while out_valid && !out_ready, the grant and all out_* fields hold stable. The arbiter re-evaluates only after a handshake or while out_valid=0.
- Handshake (out_valid && out_ready): pop the head of the granted hart and set last_grant to that hart.
- Push and pop on the same hart in the same cycle: count_h += n − 1.
- out_* are driven from the registered FIFO heads through the arbiter mux. There is no combinational path from valid/order inputs to out_*.
- Sticky flags clear only on reset.

## Timing
- Reset values: out_valid=0, out_hart=0, out_order=0, out_insn=0, out_pc=0, out_trap=0, out_mode=0, overflow=0, gap_err=0, all counts and pointers 0, checker unarmed.
- Latency: a retirement written at edge N appears on out_* after edge N (earliest accept at edge N+1), if its hart wins arbitration.
- Throughput: one entry per cycle total across all harts.
- Wrap-around: read and write pointers wrap modulo DEPTH. Full is count=DEPTH; empty is count=0.
- Reset mid-operation discards all FIFO contents and the in-flight output immediately, asynchronously.

## Configuration
- RVVI_RETIRE_ORDER_CHECK_EN defined: per-hart expected-order register plus armed bit.
  - Each valid lane of h is checked in ascending r, including dropped cycles.
  - If unarmed: arm, and set expected = order+1.
  - If armed and order ≠ expected: set gap_err[h], then expected = order+1. Otherwise expected += 1.
  - Later lanes in the same cycle compare against the updated expected value.
- RVVI_RETIRE_ORDER_CHECK_EN undefined: no checker logic; gap_err tied to 0.

## Test plan
- NHART=2, RETIRE=2, out_ready=1. Hart0 lanes 0,1 carry orders 1,2 in one cycle → out_order 1 then 2 on consecutive cycles, out_hart=0; no flags.
- Both harts present one entry each cycle (hart0 orders 10,11; hart1 orders 20,21) → output alternates 10,20,11,21.
- out_ready=0, hart0 pushes 4 cycles × 2 lanes with DEPTH=8 → count=8. A fifth push of 1 entry is dropped, overflow[0]=1, and out_* stays at order of first entry.
- Lanes valid=2'b10 with order 5 → single entry order 5 stored. With the checker on, next order 7 → gap_err[0]=1; following order 8 → no new error.
- At count=DEPTH, pop and push 1 entry in the same cycle → push dropped, overflow set. The next cycle, push 1 → accepted, count=DEPTH.
- Assert reset while out_valid=1 and not accepted → out_valid=0 immediately; all flags 0; the first entry after release is the newly pushed one.
